// File: rtl/axis_rr_arbiter_pkg.sv
// ============================================================================
// Module : axis_rr_arbiter_pkg
// Brief  : Shared types and constants for the packet round-robin AXIS arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package axis_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int PKT_CNT_W = 16;

  // Index width for NUM_SRC sources; a single source still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_rr_arbiter_if.sv
// ============================================================================
// Module : axis_rr_arbiter_if
// Brief  : Source-side and sink-side AXIS signals of the round-robin arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface axis_rr_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
);

  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]        s_axis_tvalid;
  logic [NUM_SRC-1:0]        s_axis_tlast;
  logic [NUM_SRC-1:0]        s_axis_tready;
  logic [DATA_W-1:0]         m_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tlast;
  logic [ID_W-1:0]           m_axis_tid;
  logic                      m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );

endinterface

`default_nettype wire

// File: rtl/axis_rr_arbiter_pick.sv
// ============================================================================
// Module : axis_rr_pick
// Brief  : Combinational round-robin pick: first requester at or after ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axis_rr_pick
  import axis_rr_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = ptr_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               any,
  output logic [PTR_W-1:0]   idx
);

  localparam logic [PTR_W:0] c_NUM = (PTR_W + 1)'(NUM_SRC);

  logic [2*NUM_SRC-1:0] w_dbl;
  logic [NUM_SRC-1:0]   w_rot;
  logic [PTR_W-1:0]     w_off;
  logic [PTR_W:0]       w_sum;

  // Rotating the doubled vector puts the ptr position at bit 0.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[NUM_SRC-1:0];

  always_comb begin
    w_off = '0;
    any   = |req;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = PTR_W'(i);
      end
    end
  end

  assign w_sum = {1'b0, ptr} + {1'b0, w_off};

  always_comb begin
    idx = w_sum[PTR_W-1:0];
    if (w_sum >= c_NUM) begin
      idx = PTR_W'(w_sum - c_NUM);
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
// ============================================================================
// Module : axis_rr_arbiter
// Brief  : Packet-level round-robin arbiter sharing one AXIS sink between sources.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic                 s_axis_aclk,
  input  logic                 s_axis_arstn,
  axis_rr_arbiter_if.slave     bus,
  output logic                 busy,
  output logic [PKT_CNT_W-1:0] pkt_count
);

  localparam int                 c_PTR_W = ptr_width(NUM_SRC);
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(NUM_SRC - 1);

  arb_state_e           r_state;
  logic [c_PTR_W-1:0]   r_rr_ptr;
  logic [c_PTR_W-1:0]   r_grant;
  logic                 r_busy;
  logic [PKT_CNT_W-1:0] r_pkt_count;
  logic [DATA_W-1:0]    r_m_tdata;
  logic                 r_m_tvalid;
  logic                 r_m_tlast;
  logic [ID_W-1:0]      r_m_tid;

  logic                 w_pick_any;
  logic [c_PTR_W-1:0]   w_pick_idx;
  logic                 w_src_ready;
  logic                 w_accept;
  logic                 w_sel_last;
  logic [DATA_W-1:0]    w_sel_data;

  axis_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (c_PTR_W)
  ) u_pick (
    .req (bus.s_axis_tvalid),
    .ptr (r_rr_ptr),
    .any (w_pick_any),
    .idx (w_pick_idx)
  );

  // The granted source may push whenever the output register is empty or draining.
  assign w_src_ready = (r_state == BUSY) && (!r_m_tvalid || bus.m_axis_tready);
  assign w_accept    = w_src_ready && bus.s_axis_tvalid[r_grant];
  assign w_sel_last  = bus.s_axis_tlast[r_grant];
  assign w_sel_data  = bus.s_axis_tdata[r_grant*DATA_W +: DATA_W];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_tready
      assign bus.s_axis_tready[gi] = w_src_ready && (r_grant == c_PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_pkt_count <= '0;
      r_m_tdata   <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_m_tid     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_grant <= w_pick_idx;
            r_busy  <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_accept && w_sel_last) begin
            r_rr_ptr    <= (r_grant == c_LAST) ? '0 : r_grant + 1'b1;
            r_busy      <= 1'b0;
            r_pkt_count <= r_pkt_count + 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_accept) begin
        r_m_tdata  <= w_sel_data;
        r_m_tlast  <= w_sel_last;
        r_m_tid    <= ID_W'(r_grant);
        r_m_tvalid <= 1'b1;
      end else if (bus.m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign bus.m_axis_tdata  = r_m_tdata;
  assign bus.m_axis_tvalid = r_m_tvalid;
  assign bus.m_axis_tlast  = r_m_tlast;
  assign bus.m_axis_tid    = r_m_tid;
  assign busy              = r_busy;
  assign pkt_count         = r_pkt_count;

endmodule

`default_nettype wire
